// File: rtl/song_pkg.sv
// Shared song-memory definitions used by both the recorder and the playback path:
// slot geometry, the finish sentinel, the default note period and the recorder state encoding.
package song_pkg;

    localparam logic [6:0] SONG_FINISH         = 7'h7F;
    localparam int         SLOT_DEPTH          = 250;
    localparam int         NOTE_LENGTH_DEFAULT = 50_000_000;
    localparam int         ADDR_BITS           = 10;

    typedef enum logic [1:0] {
        REC_IDLE      = 2'd0,
        REC_COUNTIN   = 2'd1,
        REC_RECORD    = 2'd2,
        REC_TERMINATE = 2'd3
    } rec_state_e;

    // First RAM address of a slot; slot 3 starts at 750, so ADDR_BITS is always wide enough.
    function automatic logic [ADDR_BITS-1:0] slot_base(input logic [1:0] slot_sel);
        return ADDR_BITS'(SLOT_DEPTH) * ADDR_BITS'(slot_sel);
    endfunction

endpackage

// File: rtl/note_timer.sv
// Note-period counter: counts 0..NOTE_LENGTH-1 while run_i is high and flags the
// terminal count with a one-cycle tick. Shared by the count-in and record phases.
module note_timer
    import song_pkg::*;
#(
    parameter int NOTE_LENGTH = NOTE_LENGTH_DEFAULT
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear_i,
    input  logic run_i,
    output logic tick_o
);

    localparam int            CW   = (NOTE_LENGTH > 1) ? $clog2(NOTE_LENGTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NOTE_LENGTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = run_i && (cnt_q == LAST);

endmodule

// File: rtl/song_recorder.sv
// Song recorder: samples note_in once per note period into one of four song slots and
// closes each take with the finish sentinel. Optional count-in phase: RECORDER_COUNTIN_EN.
module song_recorder
    import song_pkg::*;
#(
    parameter int NOTE_LENGTH = NOTE_LENGTH_DEFAULT
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start,
    input  logic                 stop,
    input  logic [1:0]           slot,
    input  logic [6:0]           note_in,
    output logic                 wr_en,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [7:0]           wr_data,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           notes_written,
    output logic                 countin_active
);

    rec_state_e           state_q;
    logic [ADDR_BITS-1:0] base_q;
    logic [7:0]           idx_q;
    logic                 wr_en_q;
    logic [ADDR_BITS-1:0] wr_addr_q;
    logic [7:0]           wr_data_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 tick;
    logic                 timer_clear;
    logic                 timer_run;
    logic [6:0]           sample_d;
    logic [ADDR_BITS-1:0] cur_addr_d;

`ifdef RECORDER_COUNTIN_EN
    logic [1:0]           period_q;
    logic                 countin_q;
`endif

    assign timer_clear = (state_q == REC_IDLE);
    assign timer_run   = (state_q == REC_RECORD) || (state_q == REC_COUNTIN);
    // The finish code is reserved for the sentinel, so a live 7F is stored as a rest.
    assign sample_d    = (note_in == SONG_FINISH) ? 7'h00 : note_in;
    assign cur_addr_d  = base_q + ADDR_BITS'(idx_q);

    note_timer #(
        .NOTE_LENGTH(NOTE_LENGTH)
    ) u_timer (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clear_i(timer_clear),
        .run_i  (timer_run),
        .tick_o (tick)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= REC_IDLE;
            base_q    <= '0;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef RECORDER_COUNTIN_EN
            period_q  <= '0;
            countin_q <= 1'b0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                REC_IDLE: begin
                    if (start) begin
                        base_q <= slot_base(slot);
                        idx_q  <= '0;
                        busy_q <= 1'b1;
`ifdef RECORDER_COUNTIN_EN
                        period_q  <= '0;
                        countin_q <= 1'b1;
                        state_q   <= REC_COUNTIN;
`else
                        state_q   <= REC_RECORD;
`endif
                    end
                end
`ifdef RECORDER_COUNTIN_EN
                REC_COUNTIN: begin
                    if (stop) begin
                        countin_q <= 1'b0;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= cur_addr_d;
                        wr_data_q <= {1'b0, SONG_FINISH};
                        state_q   <= REC_TERMINATE;
                    end else if (tick) begin
                        period_q <= period_q + 2'd1;
                        if (period_q == 2'd3) begin
                            countin_q <= 1'b0;
                            state_q   <= REC_RECORD;
                        end
                    end
                end
`endif
                REC_RECORD: begin
                    // Stop beats a coincident tick; the full-slot check keeps the sentinel in-slot.
                    if (stop || idx_q == 8'(SLOT_DEPTH - 1)) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= cur_addr_d;
                        wr_data_q <= {1'b0, SONG_FINISH};
                        state_q   <= REC_TERMINATE;
                    end else if (tick) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= cur_addr_d;
                        wr_data_q <= {1'b0, sample_d};
                        idx_q     <= idx_q + 8'd1;
                    end
                end
                REC_TERMINATE: begin
                    state_q <= REC_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= REC_IDLE;
            endcase
        end
    end

    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign notes_written = idx_q;
`ifdef RECORDER_COUNTIN_EN
    assign countin_active = countin_q;
`else
    assign countin_active = 1'b0;
`endif

endmodule

// File: tb/tb_song_recorder.sv
// Self-checking bench for song_recorder with a short note period: table of takes plus
// hand-written reset and count-in sequences; every RAM write is checked against exp_q.
module tb_song_recorder;
  import song_pkg::*;

  localparam int NL     = 4;
  localparam int BUDGET = 1500;
`ifdef RECORDER_COUNTIN_EN
  localparam int       FIRST_LAT = NL + 1 + 4 * NL;
  localparam logic [0:0] CI_FLAG = 1'b1;
`else
  localparam int       FIRST_LAT = NL + 1;
  localparam logic [0:0] CI_FLAG = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_in;
  logic                 start;
  logic                 stop;
  logic [1:0]           slot;
  logic [6:0]           note_in;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [7:0]           wr_data;
  logic                 busy;
  logic                 done;
  logic [7:0]           notes_written;
  logic                 countin_active;

  logic [17:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          take_notes = 0;

  typedef struct {
    logic [1:0] slot;
    logic [6:0] note;
    logic [6:0] step;
    int         k;
    int         mode;        // 0: run to full slot, 1: stop after k writes, 2: stop on the next tick
    logic       with_stop;   // stop raised together with start
    logic       busy_start;  // extra start pulse while busy
  } take_t;

  take_t tbl[6];

  song_recorder #(.NOTE_LENGTH(NL)) dut (
    .clk_in        (clk),
    .rst_in        (rst_in),
    .start         (start),
    .stop          (stop),
    .slot          (slot),
    .note_in       (note_in),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done),
    .notes_written (notes_written),
    .countin_active(countin_active)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_data(input logic [6:0] n);
    return (n == 7'h7F) ? 8'h00 : {1'b0, n};
  endfunction

  // scoreboard: every write must match the head of exp_q
  always @(negedge clk) begin
    logic [17:0] e;
    if (!rst_in && wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%h", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e[17:8]));
        check("wr_data", 32'(wr_data), 32'(e[7:0]));
      end
      if (wr_data != 8'h7F) take_notes++;
      check("notes_written_at_wr", 32'(notes_written), 32'(take_notes));
    end
  end

  task automatic run_take(input take_t t);
    int base;
    int seen;
    int lat;
    int cyc;
    logic got;
    base = SLOT_DEPTH * int'(t.slot);
    for (int i = 0; i < t.k; i++)
      exp_q.push_back({10'(base + i), exp_data(7'(int'(t.note) + i * int'(t.step)))});
    exp_q.push_back({10'(base + t.k), 8'h7F});
    take_notes = 0;
    slot = t.slot;
    note_in = t.note;
    start = 1'b1;
    stop = t.with_stop;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    slot = ~t.slot;
    check("busy_rise", 32'(busy), 32'd1);
    check("countin_flag", 32'(countin_active), 32'(CI_FLAG));
    if (t.k == 0 && t.mode != 0) begin
      stop = 1'b1;
    end else begin
      seen = 0;
      lat = 1;
      cyc = 0;
      while (seen < t.k && cyc < BUDGET) begin
        @(negedge clk);
        start = 1'b0;
        lat++;
        cyc++;
        if (wr_en) begin
          if (seen == 0) check("first_write_latency", 32'(lat), 32'(FIRST_LAT));
          seen++;
          note_in = 7'(int'(t.note) + seen * int'(t.step));
          if (seen == 1 && t.busy_start) begin
            start = 1'b1;
            slot = 2'd3;
          end
        end
      end
      if (seen < t.k) check("writes_before_timeout", 32'(seen), 32'(t.k));
      if (t.mode == 2) begin
        repeat (NL - 1) begin
          @(negedge clk);
          start = 1'b0;
        end
      end
      if (t.mode != 0) stop = 1'b1;
    end
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < BUDGET) begin
      @(negedge clk);
      stop = 1'b0;
      start = 1'b0;
      cyc++;
      if (wr_en && wr_data == 8'h7F) got = 1'b1;
    end
    check("sentinel_seen", 32'(got), 32'd1);
    check("sentinel_gap", 32'(cyc), 32'd1);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("busy_fall", 32'(busy), 32'd0);
    check("notes_written", 32'(notes_written), 32'(t.k));
    @(negedge clk);
    check("done_single", 32'(done), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_notes_written"}, 32'(notes_written), 32'd0);
    check({tag, "_countin_active"}, 32'(countin_active), 32'd0);
  endtask

  initial begin
    int seen;
    int cyc;
    int ci;
    int lat;
    logic bad;
    tbl[0] = '{slot: 2'd0, note: 7'd60,  step: 7'd0, k: 249, mode: 0, with_stop: 1'b1, busy_start: 1'b0};
    tbl[1] = '{slot: 2'd2, note: 7'd5,   step: 7'd1, k: 3,   mode: 1, with_stop: 1'b0, busy_start: 1'b1};
    tbl[2] = '{slot: 2'd1, note: 7'd20,  step: 7'd3, k: 2,   mode: 2, with_stop: 1'b0, busy_start: 1'b0};
    tbl[3] = '{slot: 2'd1, note: 7'h7D,  step: 7'd2, k: 3,   mode: 1, with_stop: 1'b0, busy_start: 1'b0};
    tbl[4] = '{slot: 2'd3, note: 7'd1,   step: 7'd0, k: 0,   mode: 1, with_stop: 1'b0, busy_start: 1'b0};
    tbl[5] = '{slot: 2'd3, note: 7'd100, step: 7'd0, k: 249, mode: 0, with_stop: 1'b0, busy_start: 1'b0};

    rst_in = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    slot = 2'd0;
    note_in = 7'd0;
    #2 rst_in = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_in = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_take(tbl[i]);
      repeat (2) @(negedge clk);
    end

    // reset in the middle of a take: no sentinel, outputs cleared
    exp_q.push_back({10'd250, 8'd9});
    exp_q.push_back({10'd251, 8'd9});
    take_notes = 0;
    slot = 2'd1;
    note_in = 7'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    cyc = 0;
    while (seen < 2 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (wr_en) seen++;
    end
    check("reset_take_writes", 32'(seen), 32'd2);
    @(posedge clk);
    #2 rst_in = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    rst_in = 1'b0;
    repeat (12) @(negedge clk);
    check("midreset_queue", 32'(exp_q.size()), 32'd0);
    check("midreset_idle_busy", 32'(busy), 32'd0);
    run_take('{slot: 2'd1, note: 7'd11, step: 7'd1, k: 2, mode: 1, with_stop: 1'b0, busy_start: 1'b0});

`ifdef RECORDER_COUNTIN_EN
    // count-in window: 4 periods flagged, silent, then first write one period later
    exp_q.push_back({10'd500, 8'd33});
    exp_q.push_back({10'd501, 8'h7F});
    take_notes = 0;
    slot = 2'd2;
    note_in = 7'd33;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ci = 0;
    cyc = 0;
    bad = 1'b0;
    while (countin_active && cyc < 200) begin
      if (wr_en) bad = 1'b1;
      ci++;
      @(negedge clk);
      cyc++;
    end
    check("countin_len", 32'(ci), 32'(4 * NL));
    check("countin_no_write", 32'(bad), 32'd0);
    lat = 0;
    while (!wr_en && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("post_countin_latency", 32'(lat), 32'(NL));
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("countin_sentinel_wr", 32'(wr_en), 32'd1);
    check("countin_sentinel_data", 32'(wr_data), 32'h7F);
    @(negedge clk);
    check("countin_done", 32'(done), 32'd1);
    check("countin_notes", 32'(notes_written), 32'd1);
`endif

    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
